mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/rv32i_types.sv | 32 +++
 rtl/mem_align.sv | 38 +++
 rtl/mem_stage_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I memory-stage types: funct3 encodings, MEM FSM state, alignment helper.
package rv32i_types;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Halfword needs addr[0]==0; word needs addr[1:0]==0. funct3[1] marks word width.
  function automatic logic misaligned_f(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic is_half;
    logic is_word;
    is_half = (funct3[1:0] == 2'b01);
    is_word = funct3[1];
    return (is_half & addr_lo[0]) | (is_word & (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane extraction / extension for loads.
module mem_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_enable,
  output logic [31:0] wdata_shifted,
  output logic [31:0] rdata_ext
);

  logic [4:0]  shamt;
  logic [31:0] rdata_sh;

  // Lane shift, byte enables and load extension from funct3 and the low address bits.
  always_comb begin
    shamt         = {addr_lo, 3'b000};
    wdata_shifted = wdata << shamt;
    rdata_sh      = rdata >> shamt;

    case (store_funct3_t'({1'b0, funct3[1:0]}))
      SB:      byte_enable = 4'b0001 << addr_lo;
      SH:      byte_enable = 4'b0011 << addr_lo;
      default: byte_enable = 4'b1111;
    endcase

    case (load_funct3_t'(funct3))
      LB:      rdata_ext = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      LBU:     rdata_ext = {24'h000000, rdata_sh[7:0]};
      LH:      rdata_ext = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      LHU:     rdata_ext = {16'h0000, rdata_sh[15:0]};
      default: rdata_ext = rdata_sh;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-cache controller: issues load/store requests, stalls the pipe
// until the cache responds, steers byte lanes and counts stall cycles.
module mem_stage_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       MEM_alu_out,
  input  logic [31:0]       MEM_rs2_out,
  input  logic [2:0]        MEM_funct3,
  input  logic              MEM_mem_read,
  input  logic              MEM_mem_write,
  input  logic              flush,
  output logic [ADDR_W-1:0] dmem_address,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [3:0]        dmem_byte_enable,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_resp,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       MEM_rdata,
  output logic              pipe_load,
  output logic              misaligned,
  output logic [31:0]       stall_count
);

  mem_state_t        state;
  logic [ADDR_W-1:0] held_addr;
  logic [2:0]        held_funct3;
  logic [31:0]       held_wdata;
  logic              held_read;
  logic              held_write;
  logic              held_flush;
  logic              ignore_resp;

  logic              busy;
  logic              resp_eff;
  logic              op_req;
  logic              mis_cond;
  logic              op_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_funct3;
  logic [31:0]       sel_wdata;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_rdata;

  // Lane logic always works on the op being serviced: live inputs in IDLE, held copies in BUSY.
  always_comb begin
    busy       = (state == BUSY);
    sel_addr   = busy ? held_addr   : MEM_alu_out[ADDR_W-1:0];
    sel_funct3 = busy ? held_funct3 : MEM_funct3;
    sel_wdata  = busy ? held_wdata  : MEM_rs2_out;
  end

  mem_align u_mem_align (
    .funct3        (sel_funct3),
    .addr_lo       (sel_addr[1:0]),
    .wdata         (sel_wdata),
    .rdata         (dmem_rdata),
    .byte_enable   (al_be),
    .wdata_shifted (al_wdata),
    .rdata_ext     (al_rdata)
  );

  // Request, handshake and result outputs; reset overrides everything to the quiet state.
  always_comb begin
    resp_eff         = dmem_resp & ~ignore_resp;
    op_req           = (MEM_mem_read | MEM_mem_write) & ~flush;
    mis_cond         = misaligned_f(MEM_funct3, MEM_alu_out[1:0]);
    op_valid         = op_req & ~mis_cond;

    dmem_address     = {sel_addr[ADDR_W-1:2], 2'b00};
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_byte_enable = '0;
    dmem_wdata       = '0;
    MEM_rdata        = '0;
    pipe_load        = 1'b1;
    misaligned       = 1'b0;

    if (reset) begin
      pipe_load = 1'b1;
    end else if (busy) begin
      dmem_read        = held_read;
      dmem_write       = held_write;
      dmem_byte_enable = al_be;
      dmem_wdata       = al_wdata;
      pipe_load        = resp_eff;
      // A flush seen at any point during the wait discards the returned data.
      if (resp_eff && held_read && !(held_flush || flush))
        MEM_rdata = al_rdata;
    end else if (op_valid) begin
      dmem_read        = MEM_mem_read;
      dmem_write       = MEM_mem_write & ~MEM_mem_read;
      dmem_byte_enable = al_be;
      dmem_wdata       = al_wdata;
      pipe_load        = resp_eff;
      if (resp_eff && MEM_mem_read)
        MEM_rdata = al_rdata;
    end else begin
      misaligned = op_req & mis_cond;
    end
  end

  // FSM state, held request copy and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      held_addr   <= '0;
      held_funct3 <= '0;
      held_wdata  <= '0;
      held_read   <= 1'b0;
      held_write  <= 1'b0;
      held_flush  <= 1'b0;
      ignore_resp <= 1'b1;
      stall_count <= '0;
    end else begin
      ignore_resp <= 1'b0;
      if (!pipe_load && (stall_count != '1))
        stall_count <= stall_count + 32'd1;
      case (state)
        IDLE: begin
          held_flush <= 1'b0;
          if (op_valid && !resp_eff) begin
            state       <= BUSY;
            held_addr   <= MEM_alu_out[ADDR_W-1:0];
            held_funct3 <= MEM_funct3;
            held_wdata  <= MEM_rs2_out;
            held_read   <= MEM_mem_read;
            held_write  <= MEM_mem_write & ~MEM_mem_read;
          end
        end
        BUSY: begin
          if (flush)
            held_flush <= 1'b1;
          if (resp_eff) begin
            state      <= IDLE;
            held_flush <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a load-result scoreboard.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] MEM_alu_out;
  logic [31:0] MEM_rs2_out;
  logic [2:0]  MEM_funct3;
  logic        MEM_mem_read;
  logic        MEM_mem_write;
  logic        flush;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_wdata;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic [31:0] MEM_rdata;
  logic        pipe_load;
  logic        misaligned;
  logic [31:0] stall_count;

  localparam logic [2:0] F_LB = 3'b000, F_LH = 3'b001, F_LW = 3'b010,
                         F_LBU = 3'b100, F_LHU = 3'b101;

  mem_stage_ctrl #(.ADDR_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .MEM_alu_out      (MEM_alu_out),
    .MEM_rs2_out      (MEM_rs2_out),
    .MEM_funct3       (MEM_funct3),
    .MEM_mem_read     (MEM_mem_read),
    .MEM_mem_write    (MEM_mem_write),
    .flush            (flush),
    .dmem_address     (dmem_address),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_wdata       (dmem_wdata),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata),
    .MEM_rdata        (MEM_rdata),
    .pipe_load        (pipe_load),
    .misaligned       (misaligned),
    .stall_count      (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag);
    logic [31:0] exp;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed=empty scoreboard expected=entry", tag);
    end else begin
      exp = sb.pop_front();
      chk(tag, MEM_rdata, exp);
    end
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    MEM_mem_read  = rd;
    MEM_mem_write = wr;
    MEM_funct3    = f3;
    MEM_alu_out   = addr;
    MEM_rs2_out   = wd;
  endtask

  task automatic set_idle();
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t lv[5];

  initial begin
    lv[0] = '{F_LH,  32'h202, 32'h8001_1234, 4'b1100, 32'hFFFF_8001};
    lv[1] = '{F_LHU, 32'h202, 32'h8001_1234, 4'b1100, 32'h0000_8001};
    lv[2] = '{F_LB,  32'h201, 32'h0000_8000, 4'b0010, 32'hFFFF_FF80};
    lv[3] = '{F_LBU, 32'h203, 32'h7F00_0000, 4'b1000, 32'h0000_007F};
    lv[4] = '{F_LH,  32'h200, 32'h0000_FFFE, 4'b0011, 32'hFFFF_FFFE};

    reset = 1'b1; flush = 1'b0; dmem_resp = 1'b0; dmem_rdata = '0;
    set_idle();

    // Reset state
    @(negedge clk);
    chk("rst_read", {31'b0, dmem_read}, 32'd0);
    chk("rst_write", {31'b0, dmem_write}, 32'd0);
    chk("rst_pipe_load", {31'b0, pipe_load}, 32'd1);
    chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
    chk("rst_rdata", MEM_rdata, 32'd0);
    chk("rst_stall", stall_count, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("idle_pipe_load", {31'b0, pipe_load}, 32'd1);
    tick();

    // LW 0x100, response three cycles later; live inputs disturbed while stalled
    set_op(1'b1, 1'b0, F_LW, 32'h100, 32'h0);
    sb.push_back(32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lw_wait_read", {31'b0, dmem_read}, 32'd1);
      chk("lw_wait_pipe_load", {31'b0, pipe_load}, 32'd0);
      chk("lw_wait_addr", dmem_address, 32'h100);
      chk("lw_wait_be", {28'b0, dmem_byte_enable}, 32'hF);
      chk("lw_wait_rdata", MEM_rdata, 32'd0);
      tick();
      if (i == 0) set_op(1'b1, 1'b0, F_LB, 32'h3FD, 32'h0);
    end
    dmem_resp = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("lw_resp_read", {31'b0, dmem_read}, 32'd1);
    chk("lw_resp_pipe_load", {31'b0, pipe_load}, 32'd1);
    chk("lw_resp_addr", dmem_address, 32'h100);
    chk_pop("lw_resp_rdata");
    tick();
    dmem_resp = 1'b0; set_idle();
    @(negedge clk);
    chk("lw_stall_count", stall_count, 32'd3);
    chk("lw_done_read", {31'b0, dmem_read}, 32'd0);
    tick();

    // SB 0x103 with same-cycle response
    set_op(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00AB);
    dmem_resp = 1'b1;
    @(negedge clk);
    chk("sb_be", {28'b0, dmem_byte_enable}, 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hAB00_0000);
    chk("sb_write", {31'b0, dmem_write}, 32'd1);
    chk("sb_read", {31'b0, dmem_read}, 32'd0);
    chk("sb_pipe_load", {31'b0, pipe_load}, 32'd1);
    chk("sb_addr", dmem_address, 32'h100);
    tick();
    dmem_resp = 1'b0; set_idle();
    @(negedge clk);
    chk("sb_no_busy_write", {31'b0, dmem_write}, 32'd0);
    chk("sb_stall_count", stall_count, 32'd3);
    tick();

    // SH 0x102: upper half lanes
    set_op(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_BEEF);
    dmem_resp = 1'b1;
    @(negedge clk);
    chk("sh_be", {28'b0, dmem_byte_enable}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hBEEF_0000);
    tick();

    // Zero-wait loads: sub-word extraction and extension
    foreach (lv[k]) begin
      set_op(1'b1, 1'b0, lv[k].f3, lv[k].addr, 32'h0);
      dmem_resp = 1'b1; dmem_rdata = lv[k].rdata;
      sb.push_back(lv[k].exp);
      @(negedge clk);
      chk($sformatf("ld%0d_be", k), {28'b0, dmem_byte_enable}, {28'b0, lv[k].be});
      chk($sformatf("ld%0d_pipe_load", k), {31'b0, pipe_load}, 32'd1);
      chk_pop($sformatf("ld%0d_rdata", k));
      tick();
    end

    // Read and write both set: read wins
    set_op(1'b1, 1'b1, F_LW, 32'h104, 32'h1111_1111);
    dmem_rdata = 32'h1234_5678;
    sb.push_back(32'h1234_5678);
    @(negedge clk);
    chk("prio_read", {31'b0, dmem_read}, 32'd1);
    chk("prio_write", {31'b0, dmem_write}, 32'd0);
    chk_pop("prio_rdata");
    tick();
    dmem_resp = 1'b0;

    // Misaligned LW / SH
    set_op(1'b1, 1'b0, F_LW, 32'h101, 32'h0);
    @(negedge clk);
    chk("mis_lw_flag", {31'b0, misaligned}, 32'd1);
    chk("mis_lw_read", {31'b0, dmem_read}, 32'd0);
    chk("mis_lw_pipe_load", {31'b0, pipe_load}, 32'd1);
    tick();
    set_op(1'b0, 1'b1, 3'b001, 32'h105, 32'h0);
    @(negedge clk);
    chk("mis_sh_flag", {31'b0, misaligned}, 32'd1);
    chk("mis_sh_write", {31'b0, dmem_write}, 32'd0);
    tick();
    set_idle();
    @(negedge clk);
    chk("mis_clear", {31'b0, misaligned}, 32'd0);
    chk("mis_stall_count", stall_count, 32'd3);
    tick();

    // Flush while BUSY: request held, data discarded
    set_op(1'b1, 1'b0, F_LW, 32'h300, 32'h0);
    sb.push_back(32'h0);
    @(negedge clk);
    chk("fl_issue_pipe_load", {31'b0, pipe_load}, 32'd0);
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("fl_hold_read", {31'b0, dmem_read}, 32'd1);
    chk("fl_hold_addr", dmem_address, 32'h300);
    chk("fl_hold_pipe_load", {31'b0, pipe_load}, 32'd0);
    tick();
    flush = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("fl_resp_read", {31'b0, dmem_read}, 32'd1);
    chk("fl_resp_pipe_load", {31'b0, pipe_load}, 32'd1);
    chk_pop("fl_resp_rdata");
    tick();
    dmem_resp = 1'b0; set_idle();
    @(negedge clk);
    chk("fl_stall_count", stall_count, 32'd5);
    tick();

    // Reset while BUSY, stray response right after reset
    set_op(1'b1, 1'b0, F_LW, 32'h400, 32'h0);
    @(negedge clk);
    chk("rb_busy_pipe_load", {31'b0, pipe_load}, 32'd0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rb_rst_read", {31'b0, dmem_read}, 32'd0);
    chk("rb_rst_pipe_load", {31'b0, pipe_load}, 32'd1);
    chk("rb_rst_rdata", MEM_rdata, 32'd0);
    tick();
    reset = 1'b0;
    set_op(1'b1, 1'b0, F_LW, 32'h500, 32'h0);
    dmem_resp = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("rb_stall_cleared", stall_count, 32'd0);
    chk("rb_stray_pipe_load", {31'b0, pipe_load}, 32'd0);
    chk("rb_stray_rdata", MEM_rdata, 32'd0);
    chk("rb_new_addr", dmem_address, 32'h500);
    tick();
    dmem_rdata = 32'h600D_F00D;
    sb.push_back(32'h600D_F00D);
    @(negedge clk);
    chk("rb_resp_pipe_load", {31'b0, pipe_load}, 32'd1);
    chk_pop("rb_resp_rdata");
    tick();
    dmem_resp = 1'b0; set_idle();
    @(negedge clk);
    chk("rb_stall_count", stall_count, 32'd1);
    chk("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
